// File: rtl/fetch_unit_icache.sv
// Instruction-fetch stage with a direct-mapped I-cache and a line-refill FSM.
// Drives the IF/ID register and refills whole lines, one word per memValid beat.
module fetch_unit_icache #(
  parameter int                 ADDR_W         = 32,
  parameter int                 DATA_W         = 32,
  parameter int                 LINES          = 16,
  parameter int                 WORDS_PER_LINE = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC       = '0,
  parameter int                 CNT_W          = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              PCSrc,
  input  logic [ADDR_W-1:0] branchTarget,
  input  logic              stall,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] pcOut,
  output logic              instValid,
  output logic              hit,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memValid,
  input  logic [DATA_W-1:0] memData,
  output logic [CNT_W-1:0]  hitCount,
  output logic [CNT_W-1:0]  missCount
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int LSB_W = OFF_W + 2;
  localparam int TAG_W = ADDR_W - IDX_W - LSB_W;

  typedef enum logic {RUN, REFILL} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pend_pc_reg;
  logic              pend_reg;
  logic [OFF_W-1:0]  beat_reg;
  logic [DATA_W-1:0] inst_reg;
  logic [ADDR_W-1:0] pc_out_reg;
  logic              inst_valid_reg;
  logic              mem_req_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [CNT_W-1:0]  hit_cnt_reg;
  logic [CNT_W-1:0]  miss_cnt_reg;

  logic [DATA_W-1:0] data_mem [LINES*WORDS_PER_LINE];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]  valid_reg;
  logic [LINES-1:0]  line_sel;

  logic [OFF_W-1:0]  pc_off;
  logic [IDX_W-1:0]  pc_idx;
  logic [TAG_W-1:0]  pc_tag;
  logic [IDX_W-1:0]  ref_idx;
  logic [TAG_W-1:0]  ref_tag;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] line_base;
  logic [DATA_W-1:0] fetch_word;
  logic              hit_w;
  logic              refill_we;
  logic              refill_last;

  assign pc_off      = pc_reg[LSB_W-1:2];
  assign pc_idx      = pc_reg[IDX_W+LSB_W-1:LSB_W];
  assign pc_tag      = pc_reg[ADDR_W-1:IDX_W+LSB_W];
  assign ref_idx     = mem_addr_reg[IDX_W+LSB_W-1:LSB_W];
  assign ref_tag     = mem_addr_reg[ADDR_W-1:IDX_W+LSB_W];
  assign target      = branchTarget & ~ADDR_W'(3);
  assign line_base   = {pc_reg[ADDR_W-1:LSB_W], {LSB_W{1'b0}}};
  assign fetch_word  = data_mem[{pc_idx, pc_off}];
  assign hit_w       = (state_reg == RUN) && valid_reg[pc_idx] && (tag_mem[pc_idx] == pc_tag);
  assign refill_we   = (state_reg == REFILL) && memValid;
  assign refill_last = refill_we && (&beat_reg);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Line data and tags carry no reset; the valid bits alone decide what hits.
  always_ff @(posedge Clk) begin
    if (refill_we)
      data_mem[{ref_idx, beat_reg}] <= memData;
    if (refill_last)
      tag_mem[ref_idx] <= ref_tag;
  end

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_line_sel
      assign line_sel[gi] = (ref_idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      valid_reg <= '0;
    else if (refill_last)
      valid_reg <= valid_reg | line_sel;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg      <= RUN;
      pc_reg         <= RESET_PC;
      pend_pc_reg    <= '0;
      pend_reg       <= 1'b0;
      beat_reg       <= '0;
      inst_reg       <= '0;
      pc_out_reg     <= '0;
      inst_valid_reg <= 1'b0;
      mem_req_reg    <= 1'b0;
      mem_addr_reg   <= '0;
      hit_cnt_reg    <= '0;
      miss_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        RUN: begin
          if (PCSrc) begin
            pc_reg         <= target;
            inst_valid_reg <= 1'b0;
          end else if (!stall) begin
            if (hit_w) begin
              inst_reg       <= fetch_word;
              pc_out_reg     <= pc_reg;
              inst_valid_reg <= 1'b1;
              pc_reg         <= pc_reg + ADDR_W'(4);
              hit_cnt_reg    <= sat_inc(hit_cnt_reg);
            end else begin
              inst_valid_reg <= 1'b0;
              mem_req_reg    <= 1'b1;
              mem_addr_reg   <= line_base;
              beat_reg       <= '0;
              pend_reg       <= 1'b0;
              miss_cnt_reg   <= sat_inc(miss_cnt_reg);
              state_reg      <= REFILL;
            end
          end
        end
        REFILL: begin
          // A redirect never aborts the refill; the newest target is applied on exit.
          if (PCSrc) begin
            pend_reg    <= 1'b1;
            pend_pc_reg <= target;
          end
          if (memValid) begin
            beat_reg <= beat_reg + 1'b1;
            if (&beat_reg) begin
              mem_req_reg <= 1'b0;
              state_reg   <= RUN;
              if (PCSrc)
                pc_reg <= target;
              else if (pend_reg)
                pc_reg <= pend_pc_reg;
            end
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  assign inst      = inst_reg;
  assign pcOut     = pc_out_reg;
  assign instValid = inst_valid_reg;
  assign hit       = hit_w;
  assign memReq    = mem_req_reg;
  assign memAddr   = mem_addr_reg;
  assign hitCount  = hit_cnt_reg;
  assign missCount = miss_cnt_reg;

endmodule

// File: tb/tb_fetch_unit_icache.sv
// Scoreboarded bench for fetch_unit_icache: stimulus queues expected fetches and
// refill addresses; a negedge monitor pops and compares as the DUT presents them.
module tb_fetch_unit_icache;

  logic        Clk, Rst, PCSrc, stall, memValid;
  logic [31:0] branchTarget, memData, inst, pcOut, memAddr;
  logic        instValid, hit, memReq;
  logic [15:0] hitCount, missCount;
  logic        mem_spur;

  logic [31:0] exp_fetch[$];
  logic [31:0] exp_miss[$];
  int          n_vec = 0;
  int          n_err = 0;

  fetch_unit_icache dut (
    .Clk(Clk), .Rst(Rst), .PCSrc(PCSrc), .branchTarget(branchTarget), .stall(stall),
    .inst(inst), .pcOut(pcOut), .instValid(instValid), .hit(hit),
    .memReq(memReq), .memAddr(memAddr), .memValid(memValid), .memData(memData),
    .hitCount(hitCount), .missCount(missCount)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Memory image: every word is its byte address XOR a fixed pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!memReq && n < 20) begin tick(); n++; end
    check(name, 32'(memReq), 32'd1);
  endtask

  task automatic wait_noreq(input string name);
    int n = 0;
    while (memReq && n < 20) begin tick(); n++; end
    check(name, 32'(memReq), 32'd0);
  endtask

  task automatic wait_iv(input string name);
    int n = 0;
    while (!instValid && n < 20) begin tick(); n++; end
    check(name, 32'(instValid), 32'd1);
  endtask

  // Memory responder: one beat per cycle while memReq, ascending addresses.
  initial begin
    int rbeat = 0;
    memValid = 1'b0;
    memData  = '0;
    forever begin
      @(negedge Clk);
      if (!memReq) rbeat = 0;
      memValid = memReq || mem_spur;
      memData  = mem_word(memAddr + 32'(rbeat * 4));
      @(posedge Clk);
      if (memValid && memReq) rbeat++;
    end
  end

  // Monitor: refill starts and accepted IF/ID words are checked against the queues.
  initial begin
    logic        prev_req = 1'b0;
    logic [31:0] e;
    forever begin
      @(negedge Clk);
      if (!Rst && memReq && !prev_req) begin
        if (exp_miss.size() == 0) begin
          check("unexpected_refill", memAddr, 32'hFFFF_FFFF);
        end else begin
          e = exp_miss.pop_front();
          $display("refill  memAddr=0x%08h expected 0x%08h", memAddr, e);
          check("refill_addr", memAddr, e);
        end
      end
      prev_req = memReq;
      if (!Rst && instValid && !stall) begin
        if (exp_fetch.size() == 0) begin
          check("unexpected_fetch", pcOut, 32'hFFFF_FFFF);
        end else begin
          e = exp_fetch.pop_front();
          $display("fetch   pcOut=0x%08h inst=0x%08h expected pc 0x%08h", pcOut, inst, e);
          check("fetch_pc", pcOut, e);
          check("fetch_inst", inst, mem_word(e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b0; PCSrc = 1'b0; stall = 1'b0; branchTarget = '0; mem_spur = 1'b0;
    #2 Rst = 1'b1;
    tick(); tick();
    check("rst_inst", inst, 32'h0);
    check("rst_pcOut", pcOut, 32'h0);
    check("rst_instValid", 32'(instValid), 32'd0);
    check("rst_memReq", 32'(memReq), 32'd0);
    check("rst_memAddr", memAddr, 32'h0);
    check("rst_hitCount", 32'(hitCount), 32'd0);
    check("rst_missCount", 32'(missCount), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);

    // Cold miss at 0x0, sequential hits 0x0..0xC, miss at 0x10.
    exp_miss.push_back(32'h0);
    exp_fetch.push_back(32'h0); exp_fetch.push_back(32'h4);
    exp_fetch.push_back(32'h8); exp_fetch.push_back(32'hC);
    exp_miss.push_back(32'h10);
    Rst = 1'b0;
    tick();
    check("t1_missCount1", 32'(missCount), 32'd1);
    check("t1_memReq", 32'(memReq), 32'd1);
    repeat (5) tick();
    check("t1_first_valid", 32'(instValid), 32'd1);
    check("t1_hit_at_4", 32'(hit), 32'd1);
    repeat (4) tick();
    check("t1_missCount2", 32'(missCount), 32'd2);
    check("t1_hitCount4", 32'(hitCount), 32'd4);
    check("t1_refill10", 32'(memReq), 32'd1);
    stall = 1'b1;
    repeat (6) tick();
    check("t1_refill_done", 32'(memReq), 32'd0);
    check("t1_stall_refill_iv", 32'(instValid), 32'd0);
    check("t1_hit_10", 32'(hit), 32'd1);

    // Redirect to 0x4, then a 3-cycle stall holding pcOut=0x8.
    exp_fetch.push_back(32'h4); exp_fetch.push_back(32'h8); exp_fetch.push_back(32'hC);
    PCSrc = 1'b1; branchTarget = 32'h4; stall = 1'b0;
    tick();
    PCSrc = 1'b0;
    check("t2_squash", 32'(instValid), 32'd0);
    check("t2_hit4", 32'(hit), 32'd1);
    check("t2_no_memReq", 32'(memReq), 32'd0);
    tick(); tick();
    stall = 1'b1;
    check("t4_hitCount_pre", 32'(hitCount), 32'd6);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_hold_pcOut", pcOut, 32'h8);
      check("t4_hold_iv", 32'(instValid), 32'd1);
      check("t4_hold_inst", inst, mem_word(32'h8));
      check("t4_hold_hitCount", 32'(hitCount), 32'd6);
    end
    stall = 1'b0;
    tick();
    stall = 1'b1;
    check("t4_release_pcOut", pcOut, 32'hC);
    check("t4_hitCount_post", 32'(hitCount), 32'd7);

    // Redirect during the second refill beat is deferred to the end of the refill.
    exp_miss.push_back(32'h40); exp_miss.push_back(32'h100);
    PCSrc = 1'b1; branchTarget = 32'h40; stall = 1'b0;
    tick();
    PCSrc = 1'b0;
    check("t3_squash", 32'(instValid), 32'd0);
    wait_req("t3_miss40");
    tick();
    PCSrc = 1'b1; branchTarget = 32'h103;
    tick();
    PCSrc = 1'b0;
    check("t3_refill_continues", 32'(memReq), 32'd1);
    tick(); tick();
    check("t3_refill_done", 32'(memReq), 32'd0);
    check("t3_no_hit_100", 32'(hit), 32'd0);
    check("t3_missCount3", 32'(missCount), 32'd3);
    tick();
    check("t3_miss100", 32'(memReq), 32'd1);
    check("t3_missCount4", 32'(missCount), 32'd4);
    stall = 1'b1;
    wait_noreq("t3_refill100_done");
    tick();

    // Conflict: 0x100 now owns index 0, so returning to 0x0 misses again.
    exp_fetch.push_back(32'h100); exp_fetch.push_back(32'h0);
    exp_miss.push_back(32'h0);
    stall = 1'b0;
    tick();
    PCSrc = 1'b1; branchTarget = 32'h0;
    tick();
    PCSrc = 1'b0;
    check("t5_squash", 32'(instValid), 32'd0);
    wait_req("t5_conflict_miss");
    check("t5_missCount5", 32'(missCount), 32'd5);
    wait_iv("t5_fetch0");
    stall = 1'b1;
    check("t5_hitCount9", 32'(hitCount), 32'd9);
    check("t5_hit_4", 32'(hit), 32'd1);

    // Reset in the middle of a refill; late memValid while in reset is ignored.
    exp_miss.push_back(32'h80);
    stall = 1'b0; PCSrc = 1'b1; branchTarget = 32'h80;
    tick();
    PCSrc = 1'b0;
    wait_req("t6_miss80");
    tick(); tick();
    Rst = 1'b1;
    #1;
    check("t6_memReq", 32'(memReq), 32'd0);
    check("t6_instValid", 32'(instValid), 32'd0);
    check("t6_pcOut", pcOut, 32'h0);
    check("t6_inst", inst, 32'h0);
    check("t6_memAddr", memAddr, 32'h0);
    check("t6_hitCount", 32'(hitCount), 32'd0);
    check("t6_missCount", 32'(missCount), 32'd0);
    check("t6_hit", 32'(hit), 32'd0);
    mem_spur = 1'b1;
    tick(); tick();
    check("t6_spur_memReq", 32'(memReq), 32'd0);
    mem_spur = 1'b0;
    tick();
    exp_miss.push_back(32'h0);
    exp_fetch.push_back(32'h0);
    Rst = 1'b0;
    wait_req("t6_restart_miss");
    check("t6_restart_missCount", 32'(missCount), 32'd1);
    wait_iv("t6_restart_fetch");
    PCSrc = 1'b1; branchTarget = 32'h0;
    tick();
    PCSrc = 1'b0; stall = 1'b1;
    check("t6_restart_hitCount", 32'(hitCount), 32'd1);
    tick(); tick();

    check("fetch_queue_empty", 32'(exp_fetch.size()), 32'd0);
    check("miss_queue_empty", 32'(exp_miss.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
